// File: rtl/sha256_w_window_ctrl.sv
// SHA-256 W window controller: loads a 512-bit block, streams W[0..63], and feeds/captures the expander.
// Optional SHA256_WWIN_ROUND_IDX_EN adds w_idx (current round index) and busy outputs.
//
// state    | meaning
// S_IDLE   | waiting for a block; blk_ready high
// S_STREAM | presenting W[t] to the round core; issuing expander operands for t+2
module sha256_w_window_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int ISSUE_LEAD = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         exp_write_en,
  output logic [159:0] exp_block,
  input  logic [31:0]  exp_w,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic         done
`ifdef SHA256_WWIN_ROUND_IDX_EN
  ,
  output logic [5:0]   w_idx,
  output logic         busy
`endif
);

  localparam logic [5:0] LAST_T      = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] FIRST_ISSUE = 6'(16 - ISSUE_LEAD);
  localparam logic [5:0] LAST_ISSUE  = 6'(NUM_ROUNDS - 1 - ISSUE_LEAD);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t      state, state_nxt;
  logic [5:0]  t;
  logic [31:0] slot [16];
  logic        wb_pending;
  logic [3:0]  wb_idx;
  logic        acc;
  logic        load;
  logic [3:0]  i_slot;

  assign i_slot = t[3:0] + 4'(ISSUE_LEAD);

  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    blk_ready    = 1'b0;
    w_valid      = 1'b0;
    w_data       = 32'h0;
    acc          = 1'b0;
    load         = 1'b0;
    done         = 1'b0;
    exp_write_en = 1'b0;
    case (state)
      S_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          load      = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        w_valid      = 1'b1;
        w_data       = slot[t[3:0]];
        acc          = w_ready;
        exp_write_en = acc && (t >= FIRST_ISSUE) && (t <= LAST_ISSUE);
        if (acc && t == LAST_T) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands for issue index i = t+2: W[i-16], W[i-15], W[i-7], W[i-2]; low word unused.
  assign exp_block = {slot[i_slot], slot[i_slot + 4'd1], slot[i_slot + 4'd9],
                      slot[i_slot + 4'd14], 32'h0};

`ifdef SHA256_WWIN_ROUND_IDX_EN
  assign w_idx = t;
  assign busy  = (state == S_STREAM);
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      t          <= 6'd0;
      wb_pending <= 1'b0;
      wb_idx     <= 4'd0;
      for (int k = 0; k < 16; k++) slot[k] <= 32'h0;
    end else begin
      if (load) begin
        t <= 6'd0;
        for (int k = 0; k < 16; k++) slot[k] <= blk_data[511 - 32*k -: 32];
      end else if (wb_pending) begin
        // Capture is unconditional: the expander result is only valid for this one cycle.
        slot[wb_idx] <= exp_w;
      end
      if (acc) t <= t + 6'd1;
      wb_pending <= exp_write_en;
      if (exp_write_en) wb_idx <= i_slot;
    end
  end

endmodule

// File: tb/tb_sha256_w_window_ctrl.sv
// Bench for sha256_w_window_ctrl: golden W schedule in a scoreboard queue, behavioural expander attached.
module tb_sha256_w_window_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         exp_write_en;
  logic [159:0] exp_block;
  logic [31:0]  exp_w;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_data;
  logic         done;
`ifdef SHA256_WWIN_ROUND_IDX_EN
  logic [5:0]   w_idx;
  logic         busy;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 CLK = ~CLK;

  sha256_w_window_ctrl dut (
    .CLK(CLK), .RST(RST),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .exp_write_en(exp_write_en), .exp_block(exp_block), .exp_w(exp_w),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .done(done)
`ifdef SHA256_WWIN_ROUND_IDX_EN
    , .w_idx(w_idx), .busy(busy)
`endif
  );

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Stand-in for the downstream expander: one registered result per write_en.
  always @(posedge CLK) begin
    if (!RST) exp_w <= 32'h0;
    else if (exp_write_en)
      exp_w <= sig1(exp_block[63:32]) + exp_block[95:64] + sig0(exp_block[127:96]) + exp_block[159:128];
  end

  task automatic push_golden(input logic [511:0] b);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) q.push_back(w[i]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // mode: 0 ready tied high, 1 random backpressure, 2 five-cycle stalls at t=15 and t=61, 3 reset at t=30
  task automatic stream_block(input logic [511:0] blk, input int mode, input bit abc,
                              input bit hold_next, input logic [511:0] next_blk);
    int k, cyc, wen, dn, s15, s61;
    logic rdy;
    logic [31:0] expw;
    push_golden(blk);
    blk_data  = blk;
    blk_valid = 1'b1;
    w_ready   = 1'b0;
    #1;
    check("blk_ready_idle", 32'(blk_ready), 32'd1);
    tick();
    blk_valid = hold_next;
    blk_data  = hold_next ? next_blk : '0;
    k = 0; cyc = 0; wen = 0; dn = 0; s15 = 0; s61 = 0;
    while (q.size() > 0 && cyc < 2000) begin
      cyc++;
      if (mode == 3 && k == 30) begin
        RST = 1'b0;
        w_ready = 1'b1;
        tick();
        RST = 1'b1;
        #1;
        check("abort_w_valid", 32'(w_valid), 32'd0);
        check("abort_blk_ready", 32'(blk_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        q.delete();
        return;
      end
      case (mode)
        1: rdy = 1'($urandom_range(0, 1));
        2: begin
          rdy = 1'b1;
          if (k == 15 && s15 < 5) begin rdy = 1'b0; s15++; end
          if (k == 61 && s61 < 5) begin rdy = 1'b0; s61++; end
        end
        default: rdy = 1'b1;
      endcase
      w_ready = rdy;
      #1;
      check("w_valid", 32'(w_valid), 32'd1);
      check("blk_ready_busy", 32'(blk_ready), 32'd0);
      check("wen_while_stalled", 32'(exp_write_en && !w_ready), 32'd0);
      if (exp_write_en) wen++;
      if (done) dn++;
      if (rdy) begin
        expw = q.pop_front();
        check($sformatf("w_data[%0d]", k), w_data, expw);
        if (abc && k == 16) check("abc_w16", w_data, 32'h61626380);
        if (abc && k == 17) check("abc_w17", w_data, 32'h000F0000);
        check($sformatf("done_at[%0d]", k), 32'(done), (k == 63) ? 32'd1 : 32'd0);
        if (mode == 0 && k == 63) check("done_latency", 32'(cyc), 32'd64);
        k++;
      end else begin
        check($sformatf("stall_hold[%0d]", k), w_data, q[0]);
        check("done_stalled", 32'(done), 32'd0);
      end
      tick();
    end
    check("timeout_words_left", 32'(q.size()), 32'd0);
    check("issue_count", 32'(wen), 32'd48);
    check("done_count", 32'(dn), 32'd1);
    #1;
    check("w_valid_after_done", 32'(w_valid), 32'd0);
  endtask

  initial begin
    logic [511:0] abc_blk;
    logic [511:0] rnd_blk;
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) rnd_blk[32*i +: 32] = $urandom;

    RST = 1'b0; blk_valid = 1'b1; blk_data = abc_blk; w_ready = 1'b1;
    tick();
    tick();
    check("rst_blk_ready", 32'(blk_ready), 32'd1);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_exp_write_en", 32'(exp_write_en), 32'd0);
    check("rst_w_data", w_data, 32'h0);
    check("rst_exp_block_nz", 32'(|exp_block), 32'd0);
    blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
    RST = 1'b1;
    tick();
    #1;
    check("post_rst_w_valid", 32'(w_valid), 32'd0);
    check("post_rst_blk_ready", 32'(blk_ready), 32'd1);

    stream_block(abc_blk, 0, 1'b1, 1'b0, '0);
    stream_block(abc_blk, 1, 1'b1, 1'b0, '0);
    stream_block(abc_blk, 2, 1'b1, 1'b0, '0);
    stream_block(abc_blk, 0, 1'b1, 1'b1, rnd_blk);
    stream_block(rnd_blk, 0, 1'b0, 1'b0, '0);
    stream_block(abc_blk, 3, 1'b1, 1'b0, '0);
    stream_block(abc_blk, 0, 1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
